serial_word_feeder: RTL and testbench
=====================================

Name: serial_word_feeder

Overview:
- Upstream stage of the serial sequence detectors (e.g. the 01110 detector).
- Accepts parallel test words over a valid/ready handshake.
- Shifts each word out MSB-first, one bit per clock, on the detector's serial input `a`.
- Inserts a programmable idle gap between words, at a known idle level, and counts completed words.

Parameters:
- WIDTH, 20, bits per word (range 2..32).
- GAP, 5, idle cycles after the last bit of each word (0..255).
- IDLE_LEVEL, 1'b1, value driven on `a` when no bit is being shifted.
- CNT_W, 8, width of the completed-word counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  parallel word; bit WIDTH-1 is sent first.
- din_valid  input  1  din holds a word to send.
- din_ready  output  1  feeder can accept a word this cycle.
- a  output  1  serial bit to the detector.
- a_valid  output  1  `a` carries a word bit this cycle.
- word_done  output  1  one-cycle pulse during the last bit of a word.
- busy  output  1  state is not IDLE.
- words_sent  output  CNT_W  count of completed words; wraps modulo 2^CNT_W.

Behaviour:
- Reset: synchronous, active-high; rst has priority over all other inputs.
- Reset values: state=IDLE, shift register=0, counters=0, words_sent=0.
  - Outputs during and after reset: a=IDLE_LEVEL, a_valid=0, word_done=0, busy=0.
  - din_ready=0 while rst=1.
- State register: 2-bit, states IDLE, SHIFT, GAP.
- All outputs are decoded from registered state only; none depends combinationally on din or din_valid.
- IDLE:
  - din_ready=1.
  - Handshake = din_valid & din_ready sampled at a clock edge.
  - On handshake: load shift register with din, load bit counter with WIDTH-1, go to SHIFT.
  - din is ignored when no handshake occurs.
- SHIFT:
  - a = shift register MSB; a_valid=1; din_ready=0.
  - Each edge: shift left by 1 (zero fill) and decrement the bit counter.
  - word_done=1 in the cycle where bit counter==0.
  - Leaving SHIFT at that edge: increment words_sent, load the gap counter with GAP-1, then go to GAP if GAP>0, else IDLE.
- GAP:
  - a=IDLE_LEVEL; a_valid=0; din_ready=0.
  - Decrement the gap counter each edge; go to IDLE after the cycle where it reads 0.
  - GAP occupies exactly GAP cycles.
- Latency:
  - Handshake at edge N: bit WIDTH-1 is on `a` in cycle N..N+1, bit 0 in cycle N+WIDTH-1..N+WIDTH.
  - din_ready returns 1 after GAP further cycles.
- Throughput: one word per WIDTH+GAP+1 cycles minimum. There is always at least one IDLE cycle between words, including when GAP=0.
- din_valid held high with a new word: that word is accepted on the first IDLE cycle. A word is never accepted while busy.
- Reset mid-word or mid-gap: abort immediately to IDLE.
  - The word is dropped; no word_done pulse; words_sent is cleared.
- words_sent at all-ones: the next completed word wraps it to 0; no sticky flag.
- `a` never goes to X or Z; it is IDLE_LEVEL whenever a_valid=0.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, din_valid=0 for 10 cycles.
  - Required: a=1, a_valid=0, busy=0, din_ready=1 from the first cycle after rst falls, words_sent=0.
- Single word, defaults: din=20'h70000, one-cycle valid.
  - Required: `a` = 0,1,1,1,0 then fifteen 0s over 20 cycles with a_valid=1.
  - Required: word_done high only on bit 20; words_sent=1; then 5 GAP cycles with a=1; din_ready=1 on cycle 26 after the handshake.
  - Required: a downstream 01110 detector asserts its output in the cycle after the fifth bit.
- Back-to-back, din_valid held high, words 20'hFFFFF then 20'h00001.
  - Required: second word's first bit starts exactly WIDTH+GAP+1=26 cycles after the first.
  - Required: no handshake while busy; words_sent=2.
- GAP=0, WIDTH=4, words 4'hA, 4'h5.
  - Required: `a` = 1,0,1,0, IDLE_LEVEL, 0,1,0,1.
  - Required: exactly one idle cycle between words.
- Reset mid-word: rst asserted at bit 7 of 20'hABCDE.
  - Required: next cycle a=1, a_valid=0, state IDLE, no word_done, words_sent=0.
  - Required: the next word sends cleanly from its MSB.
- Counter wrap: CNT_W=2, send 5 words.
  - Required: words_sent sequence 1,2,3,0,1; word_done pulses exactly 5 times.

Source files
------------

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial word feeder for the serial sequence detectors: takes words over
// valid/ready, shifts them out MSB-first on `a`, then holds `a` idle for GAP cycles.
module serial_word_feeder #(
  parameter int unsigned WIDTH      = 20,
  parameter int unsigned GAP        = 5,
  parameter logic        IDLE_LEVEL = 1'b1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             a,
  output logic             a_valid,
  output logic             word_done,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);

  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] BIT_LOAD = BW'(WIDTH - 1);
  localparam logic [7:0]    GAP_LOAD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [BW-1:0]    bitcnt, bitcnt_nx;
  logic [7:0]       gapcnt, gapcnt_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      gapcnt <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nx;
      shreg  <= shreg_nx;
      bitcnt <= bitcnt_nx;
      gapcnt <= gapcnt_nx;
      cnt    <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    shreg_nx  = shreg;
    bitcnt_nx = bitcnt;
    gapcnt_nx = gapcnt;
    cnt_nx    = cnt;
    case (state)
      S_IDLE: begin
        // din_ready is 1 in IDLE whenever the register is not being reset
        if (din_valid) begin
          shreg_nx  = din;
          bitcnt_nx = BIT_LOAD;
          state_nx  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shreg_nx  = {shreg[WIDTH-2:0], 1'b0};
        bitcnt_nx = bitcnt - 1'b1;
        if (bitcnt == '0) begin
          cnt_nx    = cnt + 1'b1;
          gapcnt_nx = GAP_LOAD;
          state_nx  = (GAP > 0) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        gapcnt_nx = gapcnt - 1'b1;
        if (gapcnt == '0) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign din_ready  = (state == S_IDLE) && !rst;
  assign a_valid    = (state == S_SHIFT);
  assign a          = a_valid ? shreg[WIDTH-1] : IDLE_LEVEL;
  assign word_done  = (state == S_SHIFT) && (bitcnt == '0);
  assign busy       = (state != S_IDLE);
  assign words_sent = cnt;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Directed bench for serial_word_feeder: default config, a WIDTH=4/GAP=0 config,
// and a CNT_W=2 config for counter wrap.
module tb_serial_word_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // default configuration
  logic        rst0, v0, rdy0, a0, av0, wd0, busy0;
  logic [19:0] din0;
  logic [7:0]  ws0;
  // WIDTH=4, GAP=0
  logic        rst1, v1, rdy1, a1, av1, wd1, busy1;
  logic [3:0]  din1;
  logic [7:0]  ws1;
  // WIDTH=4, GAP=1, CNT_W=2
  logic        rst2, v2, rdy2, a2, av2, wd2, busy2;
  logic [3:0]  din2;
  logic [1:0]  ws2;

  serial_word_feeder dut0 (
    .clk(clk), .rst(rst0), .din(din0), .din_valid(v0), .din_ready(rdy0),
    .a(a0), .a_valid(av0), .word_done(wd0), .busy(busy0), .words_sent(ws0));

  serial_word_feeder #(.WIDTH(4), .GAP(0), .IDLE_LEVEL(1'b1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst1), .din(din1), .din_valid(v1), .din_ready(rdy1),
    .a(a1), .a_valid(av1), .word_done(wd1), .busy(busy1), .words_sent(ws1));

  serial_word_feeder #(.WIDTH(4), .GAP(1), .IDLE_LEVEL(1'b1), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .din(din2), .din_valid(v2), .din_ready(rdy2),
    .a(a2), .a_valid(av2), .word_done(wd2), .busy(busy2), .words_sent(ws2));

  // downstream 01110 detector fed by dut0
  logic [4:0] hist;
  logic       det;
  always_ff @(posedge clk) begin
    if (rst0) hist <= '0;
    else if (av0) hist <= {hist[3:0], a0};
  end
  assign det = (hist == 5'b01110);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [19:0] w20;
  logic [8:0]  exp_a1, exp_v1;
  int          dones;

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    din0 = '0; din1 = '0; din2 = '0;

    // reset for two cycles, then idle
    tick();
    chk1("rst_ready", rdy0, 1'b0);
    chk1("rst_a", a0, 1'b1);
    tick();
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk1("idle_a", a0, 1'b1);
      chk1("idle_av", av0, 1'b0);
      chk1("idle_busy", busy0, 1'b0);
      chk1("idle_ready", rdy0, 1'b1);
      chk1("idle_wd", wd0, 1'b0);
      chkn("idle_ws", 32'(ws0), 32'd0);
      tick();
    end

    // single word 20'h70000 with one-cycle valid
    w20 = 20'h70000;
    din0 = w20; v0 = 1'b1;
    tick();
    v0 = 1'b0; din0 = 20'hFFFFF;
    for (int i = 0; i < 20; i++) begin
      chk1("w1_a", a0, w20[19-i]);
      chk1("w1_av", av0, 1'b1);
      chk1("w1_wd", wd0, i == 19);
      chk1("w1_ready", rdy0, 1'b0);
      chk1("w1_det", det, i == 5);
      tick();
    end
    chkn("w1_ws", 32'(ws0), 32'd1);
    for (int g = 0; g < 5; g++) begin
      chk1("w1_gap_a", a0, 1'b1);
      chk1("w1_gap_av", av0, 1'b0);
      chk1("w1_gap_ready", rdy0, 1'b0);
      chk1("w1_gap_busy", busy0, 1'b1);
      tick();
    end
    chk1("w1_ready26", rdy0, 1'b1);
    chk1("w1_busy26", busy0, 1'b0);

    // back-to-back with din_valid held high
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    din0 = 20'hFFFFF; v0 = 1'b1;
    tick();
    din0 = 20'h00001;
    for (int c = 0; c < 26; c++) begin
      chk1("b2b_av", av0, c < 20);
      chk1("b2b_ready", rdy0, c == 25);
      chk1("b2b_a", a0, 1'b1);
      tick();
    end
    v0 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk1("b2b_w2_av", av0, 1'b1);
      chk1("b2b_w2_a", a0, i == 19);
      chk1("b2b_w2_wd", wd0, i == 19);
      tick();
    end
    chkn("b2b_ws", 32'(ws0), 32'd2);

    // GAP=0, WIDTH=4: A then 5 with exactly one idle cycle between
    exp_a1 = 9'b1010_1_0101;
    exp_v1 = 9'b1111_0_1111;
    din1 = 4'hA; v1 = 1'b1;
    tick();
    din1 = 4'h5;
    for (int c = 0; c < 9; c++) begin
      chk1("g0_a", a1, exp_a1[8-c]);
      chk1("g0_av", av1, exp_v1[8-c]);
      chk1("g0_ready", rdy1, c == 4);
      if (c == 5) v1 = 1'b0;
      tick();
    end
    chk1("g0_idle_ready", rdy1, 1'b1);
    chkn("g0_ws", 32'(ws1), 32'd2);

    // reset in the middle of a word (dut0 idle in its gap-free tail now)
    for (int g = 0; g < 5; g++) tick();
    w20 = 20'hABCDE;
    din0 = w20; v0 = 1'b1;
    tick();
    v0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk1("mid_a", a0, w20[19-i]);
      tick();
    end
    chkn("mid_ws_before", 32'(ws0), 32'd2);
    rst0 = 1'b1;
    tick();
    chk1("mid_a_after", a0, 1'b1);
    chk1("mid_av_after", av0, 1'b0);
    chk1("mid_busy_after", busy0, 1'b0);
    chk1("mid_wd_after", wd0, 1'b0);
    chk1("mid_ready_inrst", rdy0, 1'b0);
    chkn("mid_ws_after", 32'(ws0), 32'd0);
    rst0 = 1'b0;
    #1;
    chk1("mid_ready_post", rdy0, 1'b1);
    w20 = 20'h80001;
    din0 = w20; v0 = 1'b1;
    tick();
    v0 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk1("mid_next_a", a0, w20[19-i]);
      chk1("mid_next_wd", wd0, i == 19);
      tick();
    end
    chkn("mid_next_ws", 32'(ws0), 32'd1);

    // counter wrap with CNT_W=2
    dones = 0;
    for (int w = 0; w < 5; w++) begin
      chk1("wrap_ready", rdy2, 1'b1);
      din2 = 4'(w + 3); v2 = 1'b1;
      tick();
      v2 = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (wd2) dones++;
        tick();
      end
      chkn("wrap_ws", 32'(ws2), 32'((w + 1) % 4));
      tick();
    end
    chkn("wrap_dones", 32'(dones), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
